// File: rtl/wbuart_tx_streamer_if.sv
// Wishbone classic bus between the TX streamer (master) and wbuart_wrap (slave).
interface wbuart_tx_streamer_if;
   logic        cyc;
   logic        stb;
   logic        we;
   logic [31:0] adr;
   logic [31:0] dat_w;
   logic [3:0]  sel;
   logic        ack;
   logic [31:0] dat_r;

   modport master (
      output cyc, stb, we, adr, dat_w, sel,
      input  ack, dat_r
   );

   modport slave (
      input  cyc, stb, we, adr, dat_w, sel,
      output ack, dat_r
   );
endinterface

// File: rtl/wbuart_tx_streamer.sv
// Wishbone master that drains a byte FIFO into the wbuart_wrap TX data register,
// polling the UART status register for TX FIFO space before every write.
module wbuart_tx_streamer #(
   parameter logic [31:0] UART_BASE     = 32'h3001_0000,
   parameter int unsigned DEPTH         = 8,
   parameter int unsigned TXF_SPACE_BIT = 16,
   parameter int unsigned POLL_GAP      = 15,
   parameter int unsigned ACK_TIMEOUT   = 255
) (
   input  logic                        clk_i,
   input  logic                        rst_i,
   input  logic [7:0]                  s_data_i,
   input  logic                        s_valid_i,
   output logic                        s_ready_o,
   wbuart_tx_streamer_if.master        wbm,
   input  logic                        err_clr_i,
   output logic                        err_o,
   output logic                        busy_o
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned TW = $clog2(ACK_TIMEOUT + 1);
   localparam int unsigned GW = $clog2(POLL_GAP + 1);
   localparam logic [TW-1:0] TO_LAST  = TW'(ACK_TIMEOUT - 1);
   localparam logic [GW-1:0] GAP_LAST = GW'(POLL_GAP - 1);
   localparam logic [31:0] POLL_ADR = UART_BASE + 32'h4;
   localparam logic [31:0] TX_ADR   = UART_BASE + 32'hC;

   typedef enum logic [1:0] {StIdle, StPoll, StWrite, StWait} state_e;

   // ---------------- input FIFO ----------------
   logic [7:0]  mem_q [DEPTH];
   logic [AW:0] wr_ptr_q, rd_ptr_q;
   logic [AW:0] count;
   logic        empty, full, push, pop;
   logic [7:0]  head;

   state_e        state_q;
   logic          cyc_q, stb_q, we_q, err_q;
   logic [31:0]   adr_q, dat_q;
   logic [TW-1:0] to_cnt_q;
   logic [GW-1:0] gap_cnt_q;

   assign count     = wr_ptr_q - rd_ptr_q;
   assign empty     = (wr_ptr_q == rd_ptr_q);
   assign full      = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                      (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
   assign s_ready_o = ~full;
   assign push      = s_valid_i & ~full;
   assign pop       = (state_q == StWrite) & wbm.ack;
   assign head      = mem_q[rd_ptr_q[AW-1:0]];

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
      end else begin
         if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
         if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      end
   end

   always_ff @(posedge clk_i) begin
      if (push) mem_q[wr_ptr_q[AW-1:0]] <= s_data_i;
   end

   // ---------------- bus FSM ----------------
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q   <= StIdle;
         cyc_q     <= 1'b0;
         stb_q     <= 1'b0;
         we_q      <= 1'b0;
         adr_q     <= '0;
         dat_q     <= '0;
         to_cnt_q  <= '0;
         gap_cnt_q <= '0;
         err_q     <= 1'b0;
      end else begin
         // A timeout later in this block overrides the clear.
         if (err_clr_i) err_q <= 1'b0;
         unique case (state_q)
            StIdle: begin
               if (!empty) begin
                  state_q  <= StPoll;
                  cyc_q    <= 1'b1;
                  stb_q    <= 1'b1;
                  we_q     <= 1'b0;
                  adr_q    <= POLL_ADR;
                  dat_q    <= '0;
                  to_cnt_q <= '0;
               end
            end
            StPoll: begin
               if (wbm.ack) begin
                  if (wbm.dat_r[TXF_SPACE_BIT]) begin
                     state_q  <= StWrite;
                     we_q     <= 1'b1;
                     adr_q    <= TX_ADR;
                     dat_q    <= {24'h0, head};
                     to_cnt_q <= '0;
                  end else begin
                     state_q   <= StWait;
                     cyc_q     <= 1'b0;
                     stb_q     <= 1'b0;
                     gap_cnt_q <= '0;
                  end
               end else if (to_cnt_q == TO_LAST) begin
                  state_q   <= StWait;
                  cyc_q     <= 1'b0;
                  stb_q     <= 1'b0;
                  gap_cnt_q <= '0;
                  err_q     <= 1'b1;
               end else begin
                  to_cnt_q <= to_cnt_q + 1'b1;
               end
            end
            StWrite: begin
               if (wbm.ack) begin
                  // count still includes the byte popped this cycle
                  if (count > (AW + 1)'(1)) begin
                     state_q  <= StPoll;
                     we_q     <= 1'b0;
                     adr_q    <= POLL_ADR;
                     dat_q    <= '0;
                     to_cnt_q <= '0;
                  end else begin
                     state_q <= StIdle;
                     cyc_q   <= 1'b0;
                     stb_q   <= 1'b0;
                     we_q    <= 1'b0;
                  end
               end else if (to_cnt_q == TO_LAST) begin
                  // Abort without popping so the same byte is retried.
                  state_q   <= StWait;
                  cyc_q     <= 1'b0;
                  stb_q     <= 1'b0;
                  we_q      <= 1'b0;
                  gap_cnt_q <= '0;
                  err_q     <= 1'b1;
               end else begin
                  to_cnt_q <= to_cnt_q + 1'b1;
               end
            end
            StWait: begin
               if (gap_cnt_q == GAP_LAST) begin
                  state_q  <= StPoll;
                  cyc_q    <= 1'b1;
                  stb_q    <= 1'b1;
                  we_q     <= 1'b0;
                  adr_q    <= POLL_ADR;
                  dat_q    <= '0;
                  to_cnt_q <= '0;
               end else begin
                  gap_cnt_q <= gap_cnt_q + 1'b1;
               end
            end
            default: state_q <= StIdle;
         endcase
      end
   end

   logic unused_rdata;
   assign unused_rdata = ^wbm.dat_r;

   assign wbm.cyc   = cyc_q;
   assign wbm.stb   = stb_q;
   assign wbm.we    = we_q;
   assign wbm.adr   = adr_q;
   assign wbm.dat_w = dat_q;
   assign wbm.sel   = 4'hF;
   assign err_o     = err_q;
   assign busy_o    = ~empty | (state_q != StIdle);

endmodule
